mem_arbiter: RTL and testbench

Arbitrates cache-line miss traffic from the instruction cache (fetch side) and data cache (mem stage) of `proc` onto a single external memory port. Serialises each 512-bit line into four 128-bit beats, or assembles four beats into a line, and returns the result to the requesting cache. It sits directly downstream of the processor's cache interfaces and is the only path from the pipeline to off-chip memory.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/line_beat_buf.sv | 44 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the cache-miss memory arbiter.
package mem_arb_pkg;
  localparam int LINE_W      = 512;
  localparam int BEAT_W      = 128;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} arb_state_t;
  typedef enum logic {OWN_IC, OWN_DC} arb_owner_t;
endpackage

// File: rtl/line_beat_buf.sv
// One cache line held as BEATS beat slots; serialises writes and assembles reads.
module line_beat_buf #(
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_line,
  input  logic [BEATS*BEAT_W-1:0] line_in,
  input  logic                    clr_idx,
  input  logic                    write_beat,
  input  logic [BEAT_W-1:0]       beat_in,
  input  logic                    advance,
  output logic [BEATS*BEAT_W-1:0] line,
  output logic [BEAT_W-1:0]       beat_out,
  output logic                    last_beat
);
  localparam int IDX_W = $clog2(BEATS);

  logic [BEATS-1:0][BEAT_W-1:0] line_q;
  logic [IDX_W-1:0]             idx;

  // Index wraps naturally after the final beat, which is also the state exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          idx <= '0;
    else if (load_line || clr_idx)    idx <= '0;
    else if (write_beat || advance)   idx <= idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_line) begin
      line_q <= line_in;
    end else if (write_beat) begin
      for (int g = 0; g < BEATS; g++)
        if (idx == IDX_W'(g)) line_q[g] <= beat_in;
    end
  end

  assign line      = line_q;
  assign beat_out  = line_q[idx];
  assign last_beat = (idx == IDX_W'(BEATS-1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line misses onto one beat-wide external memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 36,
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  output logic                    ic_ready,
  output logic                    ic_rvalid,
  output logic [BEATS*BEAT_W-1:0] ic_line,
  input  logic                    dc_req,
  input  logic                    dc_we,
  input  logic [ADDR_W-1:0]       dc_addr,
  input  logic [BEATS*BEAT_W-1:0] dc_wline,
  output logic                    dc_ready,
  output logic                    dc_done,
  output logic [BEATS*BEAT_W-1:0] dc_line,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_we,
  output logic [ADDR_W-1:0]       mem_cmd_addr,
  output logic                    mem_wvalid,
  input  logic                    mem_wready,
  output logic [BEAT_W-1:0]       mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [BEAT_W-1:0]       mem_rdata
);
  localparam int LW = BEAT_W * BEATS;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic              we_q, last_dc;
  logic [ADDR_W-1:0] addr_q;
  logic [LW-1:0]     ic_line_q, dc_line_q, buf_line;
  logic [BEAT_W-1:0] beat_out;
  logic              last_beat;
  logic              grant_ic, grant_dc, grant;
  logic              load_line, clr_idx, write_beat, advance;

  // dcache wins unless it was just served ahead of a waiting icache.
  assign grant_dc = dc_req & ~(last_dc & ic_req);
  assign grant_ic = ic_req & ~grant_dc;
  assign grant    = (state == IDLE) & (ic_req | dc_req);

  always_comb begin
    state_nxt  = state;
    ic_ready   = 1'b0;
    dc_ready   = 1'b0;
    load_line  = 1'b0;
    clr_idx    = 1'b0;
    write_beat = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        ic_ready  = grant_ic;
        dc_ready  = grant_dc;
        load_line = grant_dc & dc_we;
        if (ic_req | dc_req) state_nxt = CMD;
      end
      CMD: begin
        if (mem_cmd_ready) begin
          clr_idx   = 1'b1;
          state_nxt = we_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (mem_wready) begin
          advance = 1'b1;
          if (last_beat) state_nxt = RESP;
        end
      end
      RDATA: begin
        if (mem_rvalid) begin
          write_beat = 1'b1;
          if (last_beat) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_IC;
      we_q    <= 1'b0;
      addr_q  <= '0;
      last_dc <= 1'b0;
    end else if (grant) begin
      owner   <= grant_dc ? OWN_DC : OWN_IC;
      we_q    <= grant_dc & dc_we;
      addr_q  <= (grant_dc ? dc_addr : ic_addr) & ~OFF_MASK;
      last_dc <= grant_dc & ic_req;
    end
  end

  // Per-owner copies keep the returned line stable while the buffer is reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_line_q <= '0;
      dc_line_q <= '0;
    end else if (state == RESP && !we_q) begin
      if (owner == OWN_IC) ic_line_q <= buf_line;
      else                 dc_line_q <= buf_line;
    end
  end

  line_beat_buf #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_line  (load_line),
    .line_in    (dc_wline),
    .clr_idx    (clr_idx),
    .write_beat (write_beat),
    .beat_in    (mem_rdata),
    .advance    (advance),
    .line       (buf_line),
    .beat_out   (beat_out),
    .last_beat  (last_beat)
  );

  assign ic_rvalid     = (state == RESP) & (owner == OWN_IC);
  assign dc_done       = (state == RESP) & (owner == OWN_DC);
  assign ic_line       = ic_rvalid ? buf_line : ic_line_q;
  assign dc_line       = (dc_done & ~we_q) ? buf_line : dc_line_q;
  assign mem_cmd_valid = (state == CMD);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_wvalid    = (state == WDATA);
  assign mem_wdata     = beat_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed timing cases plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 36;
  localparam int BW = 128;
  localparam int LW = 512;

  logic clk = 1'b0, rst;
  logic ic_req, ic_ready, ic_rvalid;
  logic [AW-1:0] ic_addr;
  logic [LW-1:0] ic_line;
  logic dc_req, dc_we, dc_ready, dc_done;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wline, dc_line;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic mem_wvalid, mem_wready, mem_rvalid;
  logic [BW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rvalid(ic_rvalid), .ic_line(ic_line),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wline(dc_wline),
    .dc_ready(dc_ready), .dc_done(dc_done), .dc_line(dc_line),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hs"}, LW'({ic_ready, dc_ready, ic_rvalid, dc_done, mem_cmd_valid, mem_wvalid, mem_cmd_we}), '0);
    chk({tag, "_addr"}, LW'(mem_cmd_addr), '0);
    chk({tag, "_wdata"}, LW'(mem_wdata), '0);
    chk({tag, "_ic_line"}, ic_line, '0);
    chk({tag, "_dc_line"}, dc_line, '0);
  endtask

  // transaction-level model state
  bit            busy, busy0, cmd_done, rd_pending, resp_due, m_dc, m_we, lastdc_m;
  bit            ic_acc, dc_acc, win_dc;
  int            beats_w, beats_r;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wline, rd_line, last_ic_line, last_dc_line;
  logic [63:0]   r64;
  logic [BW-1:0] dbeat [4];
  bit            wr_rdy [6];
  logic [BW-1:0] wr_exp [6];

  initial begin
    rst = 1'b1; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wline = '0;
    mem_cmd_ready = 0; mem_wready = 0; mem_rvalid = 0; mem_rdata = '0;
    dbeat[0] = {32{4'hA}}; dbeat[1] = {32{4'hB}}; dbeat[2] = {32{4'hC}}; dbeat[3] = {32{4'hD}};
    wr_rdy = '{1, 0, 0, 1, 1, 1};
    wr_exp = '{128'd1, 128'd2, 128'd2, 128'd2, 128'd3, 128'd4};
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // icache read, zero-wait memory: valid pulse at T+6
    @(negedge clk);
    ic_req = 1; ic_addr = 36'h0_0000_1234; mem_cmd_ready = 1; #1;
    chk("ic_grant", LW'({ic_ready, dc_ready}), LW'(2'b10));
    @(negedge clk); ic_req = 0; #1;
    chk("rd_cmd_valid", LW'(mem_cmd_valid), LW'(1));
    chk("rd_cmd_fields", LW'({mem_cmd_we, mem_cmd_addr}), LW'({1'b0, 36'h0_0000_1200}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_rvalid = 1; mem_rdata = dbeat[k]; #1;
      chk("rd_no_early_valid", LW'(ic_rvalid), '0);
    end
    @(negedge clk); mem_rvalid = 0; #1;
    chk("ic_rvalid_t6", LW'({ic_rvalid, dc_done}), LW'(2'b10));
    chk("ic_line_lo", LW'(ic_line[127:0]), LW'(dbeat[0]));
    chk("ic_line_hi", LW'(ic_line[511:384]), LW'(dbeat[3]));
    last_ic_line = ic_line;

    // spurious read data in IDLE
    @(negedge clk); mem_rvalid = 1; mem_rdata = {4{32'hDEAD_BEEF}}; #1;
    chk("spur_idle_cmd", LW'({mem_cmd_valid, ic_rvalid}), '0);
    @(negedge clk); mem_rvalid = 0; #1;
    chk("spur_idle_line", ic_line, last_ic_line);

    // dcache write-back with a two-cycle stall on beat 1
    @(negedge clk);
    dc_req = 1; dc_we = 1; dc_addr = 36'h0_0000_2FFF;
    for (int k = 0; k < 4; k++) dc_wline[k*BW +: BW] = BW'(k + 1);
    #1 chk("wr_grant", LW'({ic_ready, dc_ready}), LW'(2'b01));
    @(negedge clk); dc_req = 0; #1;
    chk("wr_cmd_fields", LW'({mem_cmd_valid, mem_cmd_we, mem_cmd_addr}), LW'({2'b11, 36'h0_0000_2FC0}));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); mem_wready = wr_rdy[c]; #1;
      chk("wr_beat", LW'({mem_wvalid, mem_wdata}), LW'({1'b1, wr_exp[c]}));
      chk("wr_no_early_done", LW'(dc_done), '0);
    end
    @(negedge clk); mem_wready = 0; #1;
    chk("wr_done_t8", LW'({dc_done, ic_rvalid, mem_wvalid}), LW'(3'b100));

    // reset in the middle of an icache read
    @(negedge clk); ic_req = 1; ic_addr = 36'h0_0000_1240; #1;
    @(negedge clk); ic_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mem_rvalid = 1; mem_rdata = dbeat[k];
    end
    @(negedge clk); mem_rvalid = 0; rst = 1; #1;
    chk_reset_outputs("midreset");
    @(negedge clk); rst = 0; mem_cmd_ready = 0;
    @(negedge clk); #1;
    chk("midreset_no_resp", LW'({ic_rvalid, dc_done, mem_cmd_valid}), '0);

    // randomized traffic
    busy = 0; cmd_done = 0; rd_pending = 0; resp_due = 0; lastdc_m = 0; ic_acc = 0; dc_acc = 0;
    beats_w = 0; beats_r = 0; last_ic_line = '0; last_dc_line = '0; rd_line = '0;
    for (int cyc = 0; cyc < 3500; cyc++) begin
      @(negedge clk);
      if (ic_acc) ic_req = 0;
      if (dc_acc) dc_req = 0;
      ic_acc = 0; dc_acc = 0;
      if (cyc < 3000 && !ic_req && $urandom_range(2) == 0) begin
        ic_req = 1; r64 = {$urandom, $urandom}; ic_addr = r64[AW-1:0];
      end
      if (cyc < 3000 && !dc_req && $urandom_range(1) == 0) begin
        dc_req = 1; dc_we = bit'($urandom_range(1));
        r64 = {$urandom, $urandom}; dc_addr = r64[AW-1:0];
        for (int i = 0; i < 16; i++) dc_wline[i*32 +: 32] = $urandom;
      end
      mem_cmd_ready = ($urandom_range(2) != 0);
      mem_wready    = ($urandom_range(2) != 0);
      mem_rvalid    = rd_pending ? ($urandom_range(2) != 0) : ($urandom_range(4) == 0);
      for (int i = 0; i < 4; i++) mem_rdata[i*32 +: 32] = $urandom;
      #1;
      busy0 = busy;

      // response pulse, owner and returned line
      chk("rnd_ic_rvalid", LW'(ic_rvalid), LW'(resp_due && !m_dc));
      chk("rnd_dc_done", LW'(dc_done), LW'(resp_due && m_dc));
      if (resp_due && !m_dc) begin
        chk("rnd_ic_line", ic_line, rd_line);
        last_ic_line = rd_line;
      end else begin
        chk("rnd_ic_hold", ic_line, last_ic_line);
      end
      if (resp_due && m_dc && !m_we) begin
        chk("rnd_dc_line", dc_line, rd_line);
        last_dc_line = rd_line;
      end else begin
        chk("rnd_dc_hold", dc_line, last_dc_line);
      end
      if (resp_due) begin busy = 0; resp_due = 0; end

      // write beats in line order
      chk("rnd_wvalid", LW'(mem_wvalid), LW'(busy && cmd_done && m_we && beats_w < 4));
      if (mem_wvalid && mem_wready) begin
        chk("rnd_wdata", LW'(mem_wdata), LW'(m_wline[beats_w*BW +: BW]));
        beats_w++;
        if (beats_w == 4) resp_due = 1;
      end

      // read beats from the memory model
      if (rd_pending && mem_rvalid) begin
        rd_line[beats_r*BW +: BW] = mem_rdata;
        beats_r++;
        if (beats_r == 4) begin rd_pending = 0; resp_due = 1; end
      end

      // command channel
      chk("rnd_cmd_valid", LW'(mem_cmd_valid), LW'(busy && !cmd_done));
      if (mem_cmd_valid) chk("rnd_cmd_fields", LW'({mem_cmd_we, mem_cmd_addr}), LW'({m_we, m_addr}));
      if (mem_cmd_valid && mem_cmd_ready) begin
        cmd_done = 1;
        if (!m_we) begin rd_pending = 1; beats_r = 0; end
      end

      // arbitration: dcache first, unless it was just served ahead of a waiting icache
      if (!busy0 && (ic_req || dc_req)) begin
        win_dc = dc_req && !(lastdc_m && ic_req);
        chk("rnd_grant", LW'({ic_ready, dc_ready}), LW'(win_dc ? 2'b01 : 2'b10));
        m_dc = win_dc; m_we = win_dc && dc_we;
        m_addr = win_dc ? dc_addr : ic_addr; m_addr[5:0] = '0;
        m_wline = dc_wline;
        lastdc_m = win_dc && ic_req;
        busy = 1; cmd_done = 0; beats_w = 0;
        if (win_dc) dc_acc = 1; else ic_acc = 1;
      end else begin
        chk("rnd_no_grant", LW'({ic_ready, dc_ready}), '0);
      end
    end
    chk("drain", LW'({busy, ic_req, dc_req}), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
